// File: rtl/delayed_capture_sched.sv
// Cycle-counted delayed-capture controller: queues {data, delay} requests and
// commits each to q in arrival order once its delay has elapsed.
module delayed_capture_sched #(
  parameter int DATA_W  = 1,
  parameter int DELAY_W = 5,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [DATA_W-1:0]         req_data,
  input  logic [DELAY_W-1:0]        req_delay,
  output logic [DATA_W-1:0]         q,
  output logic                      q_upd,
  output logic [$clog2(DEPTH):0]    pending,
  output logic                      busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [DELAY_W-1:0] r_rem  [DEPTH];
  logic               r_vld  [DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_q;
  logic               r_q_upd;

  logic w_ready, w_acc, w_commit;

  // Ready comes from the registered count only, so a same-edge pop never frees a slot.
  assign w_ready  = (r_cnt < FULL);
  assign w_acc    = req_valid && w_ready;
  assign w_commit = r_vld[r_rptr] && (r_rem[r_rptr] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_rem[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_acc && (r_wptr == PTR_W'(i))) begin
          r_vld[i]  <= 1'b1;
          r_data[i] <= req_data;
          r_rem[i]  <= req_delay;
        end else if (w_commit && (r_rptr == PTR_W'(i))) begin
          r_vld[i]  <= 1'b0;
        end else if (r_vld[i] && (r_rem[i] != '0)) begin
          r_rem[i]  <= r_rem[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_q_upd <= 1'b0;
    end else begin
      if (w_acc)    r_wptr <= r_wptr + 1'b1;
      if (w_commit) begin
        r_rptr <= r_rptr + 1'b1;
        r_q    <= r_data[r_rptr];
      end
      r_q_upd <= w_commit;
      case ({w_acc, w_commit})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign q         = r_q;
  assign q_upd     = r_q_upd;
  assign pending   = r_cnt;
  assign busy      = (r_cnt != '0);
endmodule

// File: tb/tb_delayed_capture_sched.sv
// Scoreboard bench: the driver predicts each request's commit edge from the
// in-order/countdown rules; a negedge monitor matches every q_upd pulse.
module tb_delayed_capture_sched;
  localparam int DATA_W  = 1;
  localparam int DELAY_W = 5;
  localparam int DEPTH   = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req_valid;
  logic                   req_ready;
  logic [DATA_W-1:0]      req_data;
  logic [DELAY_W-1:0]     req_delay;
  logic [DATA_W-1:0]      q;
  logic                   q_upd;
  logic [$clog2(DEPTH):0] pending;
  logic                   busy;

  delayed_capture_sched #(.DATA_W(DATA_W), .DELAY_W(DELAY_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_delay(req_delay), .q(q), .q_upd(q_upd),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                ce;
  } exp_t;

  exp_t sb[$];
  int   mq[$];
  int   cyc = 0;
  int   mpend = 0;
  int   last_ce = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endfunction

  // Monitor: every q_upd pulse must match the oldest expected commit, on its edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (q_upd === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_q_upd", 32'(q_upd), 32'd0);
        end else begin
          chk("commit_data", 32'(q), 32'(sb[0].d));
          chk("commit_edge", 32'(cyc), 32'(sb[0].ce));
          void'(sb.pop_front());
        end
      end else if (sb.size() != 0 && sb[0].ce <= cyc) begin
        chk("missing_commit", 32'(q_upd), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus; called #1 after a rising edge.
  task automatic step(input bit v, input logic [DATA_W-1:0] d,
                      input logic [DELAY_W-1:0] dl, output bit acc);
    bit exp_ready;
    int e, ce;
    exp_ready = (mpend < DEPTH);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("pending",   32'(pending),   32'(mpend));
    chk("busy",      32'(busy),      32'(mpend != 0));
    req_valid = v;
    req_data  = d;
    req_delay = dl;
    e   = cyc + 1;
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (mq.size() != 0 && mq[0] == e) begin
      void'(mq.pop_front());
      mpend--;
    end
    if (acc) begin
      ce = e + 1 + int'(dl);
      if (ce < last_ce + 1) ce = last_ce + 1;
      last_ce = ce;
      sb.push_back('{d, ce});
      mq.push_back(ce);
      mpend++;
    end
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, a);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_q"},       32'(q),         32'd0);
    chk({tag, "_q_upd"},   32'(q_upd),     32'd0);
    chk({tag, "_pending"}, 32'(pending),   32'd0);
    chk({tag, "_busy"},    32'(busy),      32'd0);
    chk({tag, "_ready"},   32'(req_ready), 32'd1);
  endtask

  initial begin
    bit a;
    int tries;
    rst_n = 1'b0; req_valid = 1'b0; req_data = '0; req_delay = '0;
    #3;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    // Single request, delay 3.
    step(1'b1, 1'b1, 5'd3, a);
    idle(7);

    // Ordering: long-delay head blocks an already-expired follower.
    step(1'b1, 1'b1, 5'd5, a);
    step(1'b1, 1'b0, 5'd0, a);
    idle(10);

    // Fill to capacity with max delay, then hold a fifth request until accepted.
    for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(i), 5'd31, a);
    tries = 0;
    a = 1'b0;
    while (!a && tries < 60) begin
      step(1'b1, 1'b1, 5'd2, a);
      tries++;
    end
    chk("fifth_accepted", 32'(a), 32'd1);
    idle(40);

    // Streaming, delay 0, alternating data.
    for (int i = 0; i < 20; i++) step(1'b1, DATA_W'(i & 1), 5'd0, a);
    idle(4);

    // Reset while three requests are pending.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5'd10, a);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete(); mq.delete(); mpend = 0; last_ce = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(40);

    // Random traffic, mostly short delays with occasional long ones.
    for (int i = 0; i < 400; i++) begin
      logic [DELAY_W-1:0] dl;
      dl = ($urandom_range(0, 7) == 0) ? DELAY_W'($urandom_range(0, 31))
                                       : DELAY_W'($urandom_range(0, 4));
      step(($urandom_range(0, 2) != 0), DATA_W'($urandom), dl, a);
    end
    idle(80);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/delayed_capture_sched.md
Name: delayed_capture_sched

Overview:
- Schedules delayed register updates. Callers post capture requests (data value + delay in clock cycles), and the block commits each value to its output register once that request's delay has elapsed.
- Replaces ad-hoc intra-assignment delays on flop updates with a synthesizable, cycle-counted controller.
- Holds up to DEPTH pending requests and commits them strictly in arrival order.
- Sits between request producers and any register that needs delayed capture of a D input.

Parameters:
DATA_W, 1, width of captured data (q/d path)
DELAY_W, 5, width of per-request delay field (max delay 2^DELAY_W-1 cycles)
DEPTH, 4, number of pending request slots (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  capture request present
req_ready  out  1  block can accept a request this cycle
req_data  in  DATA_W  value to capture (d)
req_delay  in  DELAY_W  cycles to wait before commit
q  out  DATA_W  committed output register
q_upd  out  1  one-cycle pulse, high in the cycle q holds a newly committed value
pending  out  $clog2(DEPTH)+1  number of queued requests
busy  out  1  pending != 0

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): q=0, q_upd=0, pending=0, busy=0, all slots invalid, read/write pointers=0. req_ready=1 while in reset.
- Reset release: no commit and no q_upd until a new request is accepted.
- Accept rule:
  - A request is accepted on a rising edge when req_valid && req_ready.
  - req_ready = (pending < DEPTH), derived from registered state only.
  - No pass-through when full: a pop on the same edge does not free the slot for that edge.
- Slot storage: each slot holds {data, remaining}. On accept, remaining = req_delay. The newly written slot does not decrement on its accept edge.
- Countdown: on every edge after its accept edge, each valid slot with remaining>0 decrements by 1. remaining saturates at 0.
- Commit rule (in-order): on an edge where the head slot is valid and head.remaining==0:
  - q <= head.data, q_upd <= 1 for the following cycle;
  - head slot is freed and the read pointer advances.
  - Otherwise q holds its value and q_upd <= 0.
- Commit rate and ordering:
  - At most one commit per edge.
  - A non-head slot that reaches 0 waits until it becomes head, then commits on the next edge; entries already at 0 drain one per cycle.
- Latency: a request accepted at edge N with delay D, entering an empty queue, commits at edge N+1+D. So delay 0 gives q valid one cycle after accept.
- Simultaneous accept and commit on the same edge: pending unchanged. The pointers wrap modulo DEPTH independently.
- Committing the same value as the current q still pulses q_upd.
- pending counts 0..DEPTH.
- Any X on req_data while valid is stored as-is; req_delay is never X-checked.

Test Plan:
- Reset: drive rst_n=0 mid-cycle -> q=0, q_upd=0, pending=0, busy=0, req_ready=1 without waiting for a clock edge.
- Single request: data=1, delay=3 accepted at edge 1 -> q stays 0 through edge 4; q=1 and q_upd=1 after edge 5, q_upd=0 after edge 6; pending returns to 0.
- Ordering:
  - A(data=1, delay=5) accepted at edge 1, then B(data=0, delay=0) accepted at edge 2.
  - Expected: A commits at edge 7 (q=1), B at edge 8 (q=0); q_upd high two consecutive cycles; B never commits before A.
- Full/backpressure:
  - Accept 4 requests at delay=31.
  - Expected: pending=4, req_ready=0; a 5th request held valid is not accepted.
  - First commit at edge 33 -> pending=3 and req_ready=1 after it; 5th request accepted at edge 34.
- Streaming: requests every cycle, delay=0, data alternating 1/0 -> q follows data with 1-cycle latency, q_upd constantly 1, pending stays 1, req_ready stays 1.
- Reset mid-operation: 3 requests pending with delays 10/10/10, assert rst_n=0 at cycle 5 for 2 cycles -> q=0, pending=0 immediately; after release no q_upd pulse for 40 cycles with req_valid=0.
